// File: rtl/modmul_product_stage.sv
// modmul_product_stage: 3-stage pipelined a*b front-end feeding barrett_pipelined
module modmul_product_stage #(
  parameter int WIDTH = 32,
  parameter int LIMB  = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] m_i,
  input  logic [2*WIDTH-1:0] mu_i,
  output logic [2*WIDTH-1:0] x_o,
  output logic [2*WIDTH-1:0] m_o,
  output logic [2*WIDTH-1:0] mu_o,
  output logic               start_o,
  output logic               range_err_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   issued_o
);
  localparam int PW = 2*WIDTH;
  localparam int LW = 2*LIMB;
  logic [WIDTH-1:0] a1, b1;
  logic [PW-1:0]    m1, mu1, m2, mu2;
  logic             v1, v2, err1, err2, err_in;
  logic [LW-1:0]    ll, lh, hl, hh;
  logic [LW:0]      mid;
  logic [PW-1:0]    x_next;
  assign err_in = (m_i == '0) || (PW'(a_i) >= m_i) || (PW'(b_i) >= m_i);
  // middle cross sum keeps its carry bit before being shifted into place
  assign mid    = (LW+1)'(lh) + (LW+1)'(hl);
  assign x_next = PW'({hh, ll}) + (PW'(mid) << LIMB);
  assign busy_o = v1 | v2 | start_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      {v1, v2, start_o, err1, err2, range_err_o} <= '0;
      {a1, b1, m1, mu1, m2, mu2}                 <= '0;
      {ll, lh, hl, hh}                           <= '0;
      {x_o, m_o, mu_o}                           <= '0;
      issued_o                                   <= '0;
    end else begin
      v1       <= start_i;
      v2       <= clear_i ? 1'b0 : v1;
      start_o  <= clear_i ? 1'b0 : v2;
      issued_o <= issued_o + CNT_W'(start_o);
      if (start_i) begin
        a1   <= a_i;
        b1   <= b_i;
        m1   <= m_i;
        mu1  <= mu_i;
        err1 <= err_in;
      end
      if (v1) begin
        ll   <= LW'(a1[LIMB-1:0])     * LW'(b1[LIMB-1:0]);
        lh   <= LW'(a1[LIMB-1:0])     * LW'(b1[WIDTH-1:LIMB]);
        hl   <= LW'(a1[WIDTH-1:LIMB]) * LW'(b1[LIMB-1:0]);
        hh   <= LW'(a1[WIDTH-1:LIMB]) * LW'(b1[WIDTH-1:LIMB]);
        m2   <= m1;
        mu2  <= mu1;
        err2 <= err1;
      end
      if (v2 && !clear_i) begin
        x_o         <= x_next;
        m_o         <= m2;
        mu_o        <= mu2;
        range_err_o <= err2;
      end
    end
  end
endmodule

// File: tb/tb_modmul_product_stage.sv
// tb_modmul_product_stage: scoreboard bench for the product pipeline front-end
module tb_modmul_product_stage;
  logic        clk = 0, rst_n = 0, start = 0, clear = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] m = 0, mu = 0;
  logic [63:0] x_o, m_o, mu_o, x4, m4, mu4;
  logic        start_o, err_o, busy_o, s4, e4, b4;
  logic [15:0] issued;
  logic [3:0]  issued4;
  int          checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [63:0] x, m, mu; logic err; int due;} exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [1:0]  hist = 0;

  modmul_product_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
    .a_i(a), .b_i(b), .m_i(m), .mu_i(mu),
    .x_o(x_o), .m_o(m_o), .mu_o(mu_o), .start_o(start_o),
    .range_err_o(err_o), .busy_o(busy_o), .issued_o(issued)
  );

  modmul_product_stage #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
    .a_i(a), .b_i(b), .m_i(m), .mu_i(mu),
    .x_o(x4), .m_o(m4), .mu_o(mu4), .start_o(s4),
    .range_err_o(e4), .busy_o(b4), .issued_o(issued4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // one call per clock; ops caught in stages 1-2 by a clear leave the scoreboard
  task automatic drive(input logic s, input logic c, input logic [31:0] na, input logic [31:0] nb,
                       input logic [63:0] nm, input logic [63:0] nmu);
    @(posedge clk);
    #1;
    if (c) repeat (int'(hist[0]) + int'(hist[1])) void'(q.pop_back());
    start = s; clear = c; a = na; b = nb; m = nm; mu = nmu;
    if (s) q.push_back('{64'(na) * 64'(nb), nm, nmu,
                         (nm == 0) || (64'(na) >= nm) || (64'(nb) >= nm), cyc + 3});
    hist = {hist[0], s};
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 0; start = 0; clear = 0;
    #1;
    check("rst_start", start_o, 0);
    check("rst_x", x_o, 0);
    check("rst_m", m_o, 0);
    check("rst_mu", mu_o, 0);
    check("rst_err", err_o, 0);
    check("rst_issued", issued, 0);
    check("rst_busy", busy_o, 0);
    q.delete();
    hist = 0;
    @(posedge clk);
    #3;
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (rst_n && start_o) begin
      if (q.size() == 0) check("spurious_start", start_o, 0);
      else begin
        e = q.pop_front();
        check("x", x_o, e.x);
        check("m", m_o, e.m);
        check("mu", mu_o, e.mu);
        check("err", err_o, e.err);
        check("latency", cyc, e.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    do_reset();
    drive(1, 0, 32'h12345678, 32'h2, 64'h92153525, 64'h2CDEB2B0);
    idle(1);
    @(negedge clk);
    check("busy_inflight", busy_o, 1);
    idle(4);
    check("single_x", x_o, 64'h2468ACF0);
    check("single_busy_idle", busy_o, 0);
    drive(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'h0);
    idle(4);
    check("fw_x", x_o, 64'hFFFFFFFE00000001);
    check("fw_err", err_o, 1);
    drive(1, 0, 32'h11, 32'h22, 64'h1000, 64'h5);
    drive(1, 0, 32'h33, 32'h44, 64'h1000, 64'h6);
    drive(1, 1, 32'h55, 32'h66, 64'h1000, 64'h7);
    idle(5);
    drive(1, 0, 32'h1, 32'h2, 64'h100, 64'h1);
    drive(1, 0, 32'h3, 32'h4, 64'h100, 64'h2);
    drive(0, 1, 32'h0, 32'h0, 64'h0, 64'h0);
    idle(1);
    @(negedge clk);
    check("busy_after_clear", busy_o, 0);
    idle(4);
    for (int i = 0; i < 10; i++)
      drive(1, 0, $urandom_range(0, 32'h92153524), $urandom_range(0, 32'h92153524),
            64'h92153525, {$urandom, $urandom});
    do_reset();
    idle(5);
    drive(1, 0, 32'h7, 32'h9, 64'h40, 64'h3);
    idle(4);
    check("post_reset_issued", issued, 1);
    do_reset();
    for (int i = 0; i < 1000; i++)
      drive(1, 0, $urandom_range(0, 32'h92153524), $urandom_range(0, 32'h92153524),
            64'h92153525, {$urandom, $urandom});
    idle(4);
    check("stream_issued", issued, 1000);
    check("stream_issued4", issued4, 8);
    check("stream_busy", busy_o, 0);
    do_reset();
    for (int i = 0; i < 15; i++) drive(1, 0, i, i + 1, 64'h100, 64'h0);
    idle(4);
    check("wrap_f", issued4, 4'hF);
    drive(1, 0, 32'h5, 32'h6, 64'h100, 64'h0);
    idle(4);
    check("wrap_0", issued4, 4'h0);
    drive(1, 0, 32'h5, 32'h6, 64'h100, 64'h0);
    idle(4);
    check("wrap_1", issued4, 4'h1);
    check("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/modmul_product_stage.md
Name: modmul_product_stage

Overview:
- Pipelined front-end of the modular multiplier. Accepts operands a, b (both < m) and computes x = a*b.
- Presents x, m and mu to barrett_pipelined with a one-cycle start pulse, so that x < m^2.
- Fixed 3-cycle latency, one operation per cycle throughput, no backpressure. barrett_pipelined has no ready signal.
- Sits directly upstream of barrett_pipelined; its outputs connect 1:1 to that block's x_i, m_i, mu_i and start_i.

Parameters:
- WIDTH, 32: operand width of a and b. Product width is 2*WIDTH.
- LIMB, 16: partial-product limb width. WIDTH must be 2*LIMB.
- CNT_W, 16: width of the issued-operation counter.

Ports:
- clk_i  in  1  rising-edge clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  operand valid; one operation per asserted cycle
- clear_i  in  1  synchronous flush of in-flight operations
- a_i  in  WIDTH  operand a
- b_i  in  WIDTH  operand b
- m_i  in  2*WIDTH  modulus, sampled with the operands
- mu_i  in  2*WIDTH  Barrett constant, sampled with the operands
- x_o  out  2*WIDTH  product a*b, connects to barrett x_i
- m_o  out  2*WIDTH  modulus aligned with x_o
- mu_o  out  2*WIDTH  mu aligned with x_o
- start_o  out  1  one-cycle valid pulse, connects to barrett start_i
- range_err_o  out  1  qualified by start_o; a >= m, b >= m, or m == 0
- busy_o  out  1  any valid bit set in stages 1-3
- issued_o  out  CNT_W  count of start_o pulses, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_ni low, asynchronous): all valid bits, x_o, m_o, mu_o, range_err_o, issued_o and busy_o go to 0 immediately. Reset mid-operation discards every in-flight operation; no start_o pulse is produced for it.
- Stage 1 (edge N, start_i=1): register a, b, m, mu and valid. Compute the range error combinationally before the register: a or b, zero-extended, >= m_i, or m_i == 0.
- Stage 2 (edge N+1): split a and b into hi/lo LIMB halves and register the four products ll, lh, hl, hh (2*LIMB bits each). Carry m, mu, err and valid along.
- Stage 3 (edge N+2): x = hh<<2*LIMB + (lh+hl)<<LIMB + ll. The middle sum is kept at 2*LIMB+1 bits so its carry is not lost. x_o is exact modulo 2^(2*WIDTH); no overflow is possible.
- Outputs are registered at stage 3. start_o is high during the cycle after edge N+2, i.e. latency is 3 cycles from the start_i sample edge.
- start_o is asserted exactly once per accepted start_i. Back-to-back start_i on k consecutive cycles gives k consecutive start_o cycles in the same order.
- When start_o=0, x_o, m_o and mu_o hold their last values. Consumers use them only when start_o=1.
- range_err_o is meaningful only with start_o. x_o is still computed when it is set; the error flag travels alongside the data.
- clear_i=1 at an edge clears the valid bits of stages 1-3 at that edge; data registers are not cleared. If start_i=1 on the same edge, the new operation is accepted into stage 1 and emerges normally 3 cycles later.
- issued_o increments on every cycle where start_o=1 and wraps from 2^CNT_W-1 to 0.
- busy_o is the OR of the three stage valid bits. It is 0 after reset and after clear_i with no concurrent start_i.
- There is no internal state machine beyond the valid shift chain. The design is fully pipelined with no stall path.

Test Plan:
- Single op: m=0x92153525, mu=0x2CDEB2B0, a=0x12345678, b=0x2, start_i pulsed at edge N -> start_o high only in cycle N+3, x_o=0x2468ACF0, m_o and mu_o equal the inputs, range_err_o=0.
- Full-width carry: a=b=0xFFFFFFFF, m=0 -> x_o=0xFFFFFFFE00000001, range_err_o=1.
- Streaming: 1000 random a, b < 0x92153525 on consecutive cycles -> 1000 consecutive start_o pulses, each x_o equal to a*b in order, issued_o=1000.
- Clear: starts at edges N and N+1, clear_i with start_i at N+2 -> no start_o at N+3 or N+4; the op issued at N+2 appears at N+5.
- Async reset: rst_ni low mid-stream between clock edges -> start_o, x_o, issued_o and busy_o are 0 immediately. After release, no stale start_o appears, and a new start gives start_o 3 cycles later.
- Counter wrap: CNT_W=4, 17 operations -> issued_o reads 0xF then 0x0 then 0x1.
